// File: rtl/tile_schedule_fsm_pkg.sv
// Shared types and constants for the blocked-matmul tile sequencer.
package tile_schedule_fsm_pkg;

    localparam int unsigned IdxW   = 2;
    localparam int unsigned CountW = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StAccum,
        StNext,
        StDone
    } state_e;

    function automatic int unsigned calc_nb(int unsigned matrix_size, int unsigned block_size);
        return matrix_size / block_size;
    endfunction

endpackage

// File: rtl/tile_schedule_fsm_if.sv
// Start/done handshake plus splitter, systolic and accumulator control bundle.
interface tile_schedule_fsm_if;
    import tile_schedule_fsm_pkg::*;

    logic              start;
    logic              systolic_done;
    logic              done;
    logic              computation_valid;
    logic [IdxW-1:0]   a_row_idx;
    logic [IdxW-1:0]   a_col_idx;
    logic [IdxW-1:0]   b_row_idx;
    logic [IdxW-1:0]   b_col_idx;
    logic [IdxW-1:0]   c_row_idx;
    logic [IdxW-1:0]   c_col_idx;
    logic              start_systolic;
    logic              accumulate_result;
    logic [CountW-1:0] computation_count;

    // Sequencer side.
    modport master (
        input  start, systolic_done,
        output done, computation_valid, a_row_idx, a_col_idx, b_row_idx, b_col_idx,
               c_row_idx, c_col_idx, start_systolic, accumulate_result, computation_count
    );

    // Host and datapath side.
    modport slave (
        output start, systolic_done,
        input  done, computation_valid, a_row_idx, a_col_idx, b_row_idx, b_col_idx,
               c_row_idx, c_col_idx, start_systolic, accumulate_result, computation_count
    );

endinterface

// File: rtl/tile_schedule_fsm_tile_index_counter.sv
// Nested i/j/k tile counter (k innermost) with linear step count and last-step flag.
module tile_index_counter
    import tile_schedule_fsm_pkg::*;
#(
    parameter int unsigned Nb = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [IdxW-1:0]   i_o,
    output logic [IdxW-1:0]   j_o,
    output logic [IdxW-1:0]   k_o,
    output logic [CountW-1:0] count_o,
    output logic              last_o
);

    localparam logic [IdxW-1:0] IdxMax = IdxW'(Nb - 1);

    logic [IdxW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CountW-1:0] count_q, count_d;

    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        count_d = count_q;
        if (clear_i) begin
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            count_d = '0;
        end else if (advance_i) begin
            count_d = count_q + CountW'(1);
            if (k_q == IdxMax) begin
                k_d = '0;
                if (j_q == IdxMax) begin
                    j_d = '0;
                    i_d = (i_q == IdxMax) ? '0 : i_q + IdxW'(1);
                end else begin
                    j_d = j_q + IdxW'(1);
                end
            end else begin
                k_d = k_q + IdxW'(1);
            end
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            count_q <= '0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            count_q <= count_d;
        end
    end

    assign i_o     = i_q;
    assign j_o     = j_q;
    assign k_o     = k_q;
    assign count_o = count_q;
    assign last_o  = (i_q == IdxMax) && (j_q == IdxMax) && (k_q == IdxMax);

endmodule

// File: rtl/tile_schedule_fsm.sv
// Walks every (output block, reduction block) pair: load, launch systolic, wait, accumulate.
module tile_schedule_fsm
    import tile_schedule_fsm_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = 128,
    parameter int unsigned BLOCK_SIZE  = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    tile_schedule_fsm_if.master bus
);

    localparam int unsigned Nb = calc_nb(MATRIX_SIZE, BLOCK_SIZE);

    state_e          state_q, state_d;
    logic            cnt_clear, cnt_advance, cnt_last;
    logic [IdxW-1:0] idx_i, idx_j, idx_k;

    tile_index_counter #(
        .Nb (Nb)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cnt_clear),
        .advance_i (cnt_advance),
        .i_o       (idx_i),
        .j_o       (idx_j),
        .k_o       (idx_k),
        .count_o   (bus.computation_count),
        .last_o    (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StLoad;
                    cnt_clear = 1'b1;
                end
            end
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (bus.systolic_done) state_d = StAccum;
            StAccum: state_d = StNext;
            StNext: begin
                // cnt_last reflects the step just finished, before the advance lands.
                cnt_advance = 1'b1;
                state_d     = cnt_last ? StDone : StLoad;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.done              = (state_q == StDone);
    assign bus.start_systolic    = (state_q == StStart);
    assign bus.accumulate_result = (state_q == StAccum);
    assign bus.computation_valid = (state_q == StLoad) || (state_q == StStart) ||
                                   (state_q == StWait) || (state_q == StAccum);

    assign bus.a_row_idx = idx_i;
    assign bus.a_col_idx = idx_k;
    assign bus.b_row_idx = idx_k;
    assign bus.b_col_idx = idx_j;
    assign bus.c_row_idx = idx_i;
    assign bus.c_col_idx = idx_j;

endmodule

// File: tb/tb_tile_schedule_fsm.sv
// Scoreboard bench: nested-loop model feeds an expected-step queue, a monitor checks pulses.
module tb_tile_schedule_fsm;
    import tile_schedule_fsm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tile_schedule_fsm_if bus0 ();
    tile_schedule_fsm_if bus1 ();

    tile_schedule_fsm #(.MATRIX_SIZE(128), .BLOCK_SIZE(64)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    tile_schedule_fsm #(.MATRIX_SIZE(64), .BLOCK_SIZE(64)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {int i; int j; int k; int cnt;} step_t;

    step_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    t0 = 0;
    int    sum_n = 0;
    int    run_steps = 0;
    int    n_ss = 0;
    int    n_acc = 0;
    int    n_done = 0;
    int    acc_map[4][4];
    bit    stray_en = 1'b0;
    bit    fixed_delay = 1'b1;
    int    wait_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: every (i,j,k) in loop order, step number i*nb^2 + j*nb + k.
    task automatic begin_run(int nb);
        n_ss  = 0;
        n_acc = 0;
        n_done = 0;
        foreach (acc_map[a, b]) acc_map[a][b] = 0;
        exp_q.delete();
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < nb; j++)
                for (int k = 0; k < nb; k++)
                    exp_q.push_back('{i, j, k, (i * nb * nb + j * nb + k) % 16});
        run_steps = nb * nb * nb;
        sum_n = 0;
        t0 = cyc;
    endtask

    task automatic end_run_checks(int nb);
        check("start_systolic_pulses", n_ss, nb * nb * nb);
        check("accumulate_pulses", n_acc, nb * nb * nb);
        check("done_pulses", n_done, 1);
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < nb; j++)
                check($sformatf("acc_per_block_%0d_%0d", i, j), acc_map[i][j], nb);
    endtask

    task automatic wait_done(int budget, bit noisy);
        int base;
        int n;
        base = n_done;
        n = 0;
        while (n_done == base && n < budget) begin
            @(negedge clk);
            n++;
            if (noisy) bus0.start = (n_acc < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        bus0.start = 1'b0;
        check("done_within_budget", int'(n_done > base), 1);
    endtask

    task automatic check_quiet_outputs(string tag);
        check({tag, "_done"}, bus0.done, 0);
        check({tag, "_valid"}, bus0.computation_valid, 0);
        check({tag, "_start_systolic"}, bus0.start_systolic, 0);
        check({tag, "_accumulate"}, bus0.accumulate_result, 0);
        check({tag, "_idx_sum"}, bus0.a_row_idx + bus0.a_col_idx + bus0.b_row_idx +
              bus0.b_col_idx + bus0.c_row_idx + bus0.c_col_idx, 0);
        check({tag, "_count"}, bus0.computation_count, 0);
    endtask

    // Systolic responder for dut0; stray pulses land only outside WAIT.
    initial begin : responder
        int d;
        logic sd;
        forever begin
            @(negedge clk);
            sd = 1'b0;
            if (rst_n) begin
                wait_cnt = 0;
            end else if (bus0.start_systolic) begin
                d = fixed_delay ? 3 : int'($urandom_range(1, 4));
                wait_cnt = d;
                sum_n += d;
                sd = stray_en;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                sd = (wait_cnt == 0);
            end else begin
                sd = stray_en && ($urandom_range(0, 1) == 1);
            end
            bus0.systolic_done = sd;
        end
    end

    initial begin : monitor
        logic  prev_ss;
        logic  prev_acc;
        logic  prev_done;
        step_t e;
        prev_ss = 1'b0;
        prev_acc = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (bus0.start_systolic) begin
                    n_ss++;
                    check("start_systolic_width", prev_ss, 0);
                    check("start_systolic_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        check("start_c_row", bus0.c_row_idx, exp_q[0].i);
                        check("start_c_col", bus0.c_col_idx, exp_q[0].j);
                        check("start_a_col", bus0.a_col_idx, exp_q[0].k);
                    end
                end
                if (bus0.accumulate_result) begin
                    n_acc++;
                    check("accumulate_width", prev_acc, 0);
                    check("accumulate_valid", bus0.computation_valid, 1);
                    check("accumulate_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("acc_c_row", bus0.c_row_idx, e.i);
                        check("acc_c_col", bus0.c_col_idx, e.j);
                        check("acc_a_row", bus0.a_row_idx, e.i);
                        check("acc_a_col", bus0.a_col_idx, e.k);
                        check("acc_b_row", bus0.b_row_idx, e.k);
                        check("acc_b_col", bus0.b_col_idx, e.j);
                        check("acc_count", bus0.computation_count, e.cnt);
                    end
                    acc_map[bus0.c_row_idx][bus0.c_col_idx]++;
                end
                if (bus0.done) begin
                    n_done++;
                    check("done_width", prev_done, 0);
                    check("done_valid_low", bus0.computation_valid, 0);
                    check("done_all_steps_seen", exp_q.size(), 0);
                    check("done_cycle_total", cyc - t0 + 1, 2 + 4 * run_steps + sum_n);
                end
                prev_ss = bus0.start_systolic;
                prev_acc = bus0.accumulate_result;
                prev_done = bus0.done;
            end else begin
                prev_ss = 1'b0;
                prev_acc = 1'b0;
                prev_done = 1'b0;
            end
        end
    end

    initial begin : main
        int n;
        int ss1, acc1, done1, t1, dur1;
        logic saw1;
        bus0.start = 1'b0;
        bus0.systolic_done = 1'b0;
        bus1.start = 1'b0;
        bus1.systolic_done = 1'b0;

        // Reset held with start high.
        bus0.start = 1'b1;
        repeat (4) @(negedge clk);
        check_quiet_outputs("reset");
        check("reset_nb1_valid", bus1.computation_valid, 0);

        // Run 1: release with start still high, fixed 3-cycle systolic latency.
        begin_run(2);
        rst_n = 1'b0;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(400, 1'b0);
        end_run_checks(2);

        // Run 2: random latency, stray systolic_done, repeated start mid-run.
        fixed_delay = 1'b0;
        stray_en = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_stray_valid", bus0.computation_valid, 0);
        check("idle_stray_count", bus0.computation_count, 8);
        begin_run(2);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(400, 1'b1);
        end_run_checks(2);
        stray_en = 1'b0;
        repeat (3) @(negedge clk);
        check("no_rerun_after_done", bus0.computation_valid, 0);

        // Run 3: reset in WAIT of step 5, then a clean restart.
        fixed_delay = 1'b1;
        begin_run(2);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        n = 0;
        while (n_acc < 5 && n < 300) begin @(negedge clk); n++; end
        check("reached_step5", n_acc, 5);
        n = 0;
        while (!bus0.start_systolic && n < 20) begin @(negedge clk); n++; end
        check("step5_launch_count", bus0.computation_count, 5);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_quiet_outputs("midrun_reset");
        repeat (3) @(negedge clk);
        check("aborted_run_no_done", n_done, 0);
        rst_n = 1'b0;
        @(negedge clk);
        begin_run(2);
        fixed_delay = 1'b0;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(400, 1'b0);
        end_run_checks(2);

        // NB = 1 instance: one step, all indices zero.
        ss1 = 0;
        acc1 = 0;
        done1 = 0;
        saw1 = 1'b0;
        t1 = cyc;
        dur1 = 0;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        n = 0;
        while (done1 == 0 && n < 50) begin
            bus1.systolic_done = saw1;
            saw1 = bus1.start_systolic;
            if (bus1.start_systolic) ss1++;
            if (bus1.accumulate_result) begin
                acc1++;
                check("nb1_idx_sum", bus1.a_row_idx + bus1.a_col_idx + bus1.b_row_idx +
                      bus1.b_col_idx + bus1.c_row_idx + bus1.c_col_idx, 0);
                check("nb1_count", bus1.computation_count, 0);
            end
            if (bus1.done) begin
                done1++;
                dur1 = cyc - t1 + 1;
            end
            if (done1 == 0) begin
                @(negedge clk);
                n++;
            end
        end
        bus1.systolic_done = 1'b0;
        check("nb1_done_seen", done1, 1);
        check("nb1_start_systolic_pulses", ss1, 1);
        check("nb1_accumulate_pulses", acc1, 1);
        check("nb1_cycle_total", dur1, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_schedule_fsm.md
# tile_schedule_fsm

Control sequencer for the 128x128 blocked matrix multiplier. It walks every (output block, reduction block) pair of a tiled product C = A·B. For each pair it supplies block indices to the A/B matrix splitters, launches the 64x64 systolic array, waits for completion, then pulses the result accumulator. It sits between the top-level start/done handshake and the splitter/systolic/accumulator datapath.

## Interface
- MATRIX_SIZE, 128, full matrix dimension.
- BLOCK_SIZE, 64, tile dimension. MATRIX_SIZE/BLOCK_SIZE = NB must be an integer from 1 to 4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-high (asserted = 1). The codebase port name is kept.
- start  in  1  begin a full multiplication; sampled only in IDLE.
- systolic_done  in  1  systolic array finished the current tile; sampled only in WAIT.
- done  out  1  one-cycle pulse when all tiles have been processed.
- computation_valid  out  1  high while a tile step is in progress (LOAD through ACCUM).
- a_row_idx, a_col_idx  out  2 each  A tile indices, equal to (i, k).
- b_row_idx, b_col_idx  out  2 each  B tile indices, equal to (k, j).
- c_row_idx, c_col_idx  out  2 each  C tile indices, equal to (i, j).
- start_systolic  out  1  one-cycle launch pulse to the systolic array.
- accumulate_result  out  1  one-cycle pulse telling the accumulator to add the tile result into C[i,j].
- computation_count  out  4  linear step number, i·NB² + j·NB + k.

## Operation
- Loop counters i, j, k each run 0..NB-1. k is innermost, then j, then i is outermost.
- Total steps = NB³; with defaults NB = 2, giving 8 steps numbered 0–7.
- States:
  - IDLE → LOAD on start. The transition clears i, j, k and the step count.
  - LOAD: one cycle. Indices are stable so the splitters capture the tiles.
  - START: one cycle; start_systolic = 1.
  - WAIT: holds until systolic_done = 1, then goes to ACCUM.
  - ACCUM: one cycle; accumulate_result = 1.
  - NEXT: advances k, j, i and the step count. If that was the last step it goes to DONE, otherwise to LOAD.
  - DONE: one cycle; done = 1; then returns to IDLE.
- Outputs are Moore-decoded from state.
- Index outputs come directly from the registered counters. They stay stable from LOAD through NEXT and keep their last values in IDLE and DONE.
- start is ignored outside IDLE.
- systolic_done is ignored outside WAIT, including when it coincides with START.
- Reset, including mid-operation, forces IDLE and clears all counters. It aborts any run with no done pulse.
- Counter arithmetic is unsigned. The wrap of k to 0 carries into j, and the wrap of j carries into i.

## Timing
- Reset values:
  - done, computation_valid, start_systolic, accumulate_result = 0.
  - All indices = 0.
  - computation_count = 0.
- Rising edge sampling start = 1 in IDLE → LOAD in the next cycle.
- Per step: LOAD(1) + START(1) + WAIT(n) + ACCUM(1) + NEXT(1) cycles, where n ≥ 1 is the number of WAIT cycles up to and including the one in which systolic_done is seen.
- done is asserted exactly 1 cycle after the final NEXT.
- Total cycles from start to done = 1 + Σ(4 + n) + 1.
- start_systolic and accumulate_result are each exactly one cycle wide, once per step.

## Structure
- Shared package holds:
  - state enum: IDLE, LOAD, START, WAIT, ACCUM, NEXT, DONE;
  - function NB = MATRIX_SIZE/BLOCK_SIZE;
  - index width constant (2).
- One natural sub-module: tile_index_counter, the nested i/j/k counter with a last-step flag and the step count.
- The splitter, systolic array and accumulator are separate blocks and are not part of this one.

## Test plan
- Reset held with start = 1 → all outputs 0 and the state stays IDLE. On release, start then runs normally.
- Full run (defaults) with systolic_done returned 3 cycles after each start_systolic:
  - 8 start_systolic pulses and 8 accumulate_result pulses;
  - C index sequence (0,0)(0,0)(0,1)(0,1)(1,0)(1,0)(1,1)(1,1);
  - k alternates 0,1;
  - computation_count runs 0..7;
  - one done pulse, with total cycle count matching the formula above.
- Index consistency at every accumulate_result:
  - a_row = c_row and b_col = c_col;
  - a_col = b_row = k;
  - each C block is accumulated exactly 2 times.
- A stray systolic_done in IDLE, LOAD or START, and a second start mid-run → no effect on the sequence or the pulse counts.
- Reset asserted during WAIT of step 5 → immediate IDLE with no done pulse. A following start restarts from step 0.
- MATRIX_SIZE = 64, BLOCK_SIZE = 64 (NB = 1) → a single step with all indices 0, then done.
